pipeline_image_upload_writer: RTL and testbench
===============================================

Name: pipeline_image_upload_writer

Overview:
Downstream consumer of the SPI control stage's image-pixel stream (pixel x, pixel y, pixel data, one-cycle ready strobe). Converts each accepted pixel into a linear framebuffer address, buffers it in a small show-ahead FIFO, and issues write requests to the framebuffer memory arbiter over a req/ack handshake. This decouples bursty SPI pixel arrival from arbiter stalls caused by video readout.

Parameters:
PRECISION, 11, width of pixel_x/pixel_y coordinates
PIXEL_SIZE, 16, pixel data width (RGB565)
RESOLUTION_X, 800, image width in pixels
RESOLUTION_Y, 600, image height in pixels
ADDR_WIDTH, 19, framebuffer word address width (must satisfy 2^ADDR_WIDTH >= RESOLUTION_X*RESOLUTION_Y)
FIFO_DEPTH_LOG2, 3, FIFO depth = 2^FIFO_DEPTH_LOG2 entries (8)

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous; discard input stage and FIFO contents
pixel_x  input  PRECISION  column of incoming pixel
pixel_y  input  PRECISION  row of incoming pixel
pixel_data  input  PIXEL_SIZE  incoming pixel value
pixel_ready  input  1  one-cycle strobe; pixel_x/y/data valid this cycle
mem_wr_req  output  1  write request pending; high whenever FIFO non-empty
mem_wr_addr  output  ADDR_WIDTH  linear address of FIFO head
mem_wr_data  output  PIXEL_SIZE  data of FIFO head
mem_wr_ack  input  1  arbiter accepts head this cycle; only meaningful while mem_wr_req=1
frame_done  output  1  one-cycle pulse when the write of pixel (RESOLUTION_X-1, RESOLUTION_Y-1) is acked
overflow  output  1  sticky; a pixel was dropped because the FIFO was full
range_error  output  1  sticky; a pixel with x>=RESOLUTION_X or y>=RESOLUTION_Y was dropped
fifo_level  output  FIFO_DEPTH_LOG2+1  current FIFO occupancy (0..2^FIFO_DEPTH_LOG2)

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO empty, fifo_level=0, mem_wr_req=0, mem_wr_addr=0, mem_wr_data=0, frame_done=0, overflow=0, range_error=0, input-stage valid=0. Reset mid-transfer drops all buffered pixels; no partial request remains.
- Stage 1 (address stage, 1 cycle): on pixel_ready, range check. In range: register addr = pixel_y*RESOLUTION_X + pixel_x (computed at ADDR_WIDTH, no truncation for legal coords), data, last flag (x==RESOLUTION_X-1 && y==RESOLUTION_Y-1), valid=1. Out of range: valid=0, set range_error. Valid otherwise clears each cycle.
- Stage 2 (FIFO push): when stage-1 valid, push {addr, data, last}. Push is accepted if not full, or if full and a pop occurs in the same cycle. Otherwise the pixel is dropped and overflow is set.
- Latency: pixel_ready at cycle N -> entry visible at FIFO head / mem_wr_req=1 at cycle N+2 when the FIFO was empty.
- Output: show-ahead. mem_wr_addr/mem_wr_data always reflect the head entry while mem_wr_req=1. Pop on mem_wr_ack && mem_wr_req. Ack while req=0 is ignored. Back-to-back acks drain one entry per cycle.
- Simultaneous push and pop: fifo_level unchanged; pointers both advance. Push into empty FIFO plus ack in the same cycle: no pop (req was 0).
- frame_done: registered; asserts the cycle after the ack of an entry with last=1.
- Pointers are FIFO_DEPTH_LOG2 bits and wrap modulo depth; full = (level == 2^FIFO_DEPTH_LOG2).
- flush=1: empties FIFO, clears stage-1 valid, suppresses any same-cycle push and pop, and clears overflow and range_error. Flush has priority over all other events. A pixel_ready in the flush cycle is discarded.
- Sticky flags clear only on reset or flush.
- No state machine beyond the FIFO. Pipeline occupancy is the only sequential control.

Decomposition:
- Shared package: RESOLUTION_X/RESOLUTION_Y defaults, FB_ADDR_WIDTH, PIXEL_SIZE, and a function fb_linear_addr(x, y). Also used by the video read side so both sides agree on the mapping.
- One natural sub-module: sync_fifo_fwft, a parameterised show-ahead FIFO with width, log2 depth, push, pop, full, empty and level, and async active-low reset. The top holds the address stage, range check, flags and frame_done.

Test Plan:
- Single pixel x=5, y=2, data=16'hF800, ack held high -> mem_wr_req rises 2 cycles after strobe with addr=1605 and data=F800; it drops the cycle after the ack; fifo_level returns to 0.
- Nine strobes on consecutive cycles with ack tied low -> fifo_level=8, overflow=1, and the 9th pixel is absent. On releasing ack, 8 writes drain in order with addresses 0..7.
- Full FIFO, ack=1 and a new strobe arriving at stage 2 in the same cycle -> push accepted, level stays 8, overflow stays 0.
- Strobe x=800, y=0 and strobe x=0, y=600 -> no request issued, range_error=1. Then flush -> range_error=0.
- Pixel (799, 599) written and acked -> frame_done pulses exactly once, one cycle after the ack, with addr=479999.
- 4 entries buffered, then rst_n pulsed low mid-cycle -> all outputs go to their reset values immediately (asynchronously), and no further requests are made after release.

Source files
------------

// File: rtl/pipeline_image_upload_writer_pkg.sv
// rtl/pipeline_image_upload_writer_pkg.sv - shared framebuffer geometry and pixel-to-address mapping
package pipeline_image_upload_writer_pkg;

   localparam int FB_PRECISION    = 11;
   localparam int FB_PIXEL_SIZE   = 16;
   localparam int FB_RESOLUTION_X = 800;
   localparam int FB_RESOLUTION_Y = 600;
   localparam int FB_ADDR_WIDTH   = 19;

   // Row-major linear word address; the video read side uses the same mapping.
   function automatic logic [FB_ADDR_WIDTH-1:0] fb_linear_addr(
      input logic [FB_PRECISION-1:0] x,
      input logic [FB_PRECISION-1:0] y
   );
      return FB_ADDR_WIDTH'(y) * FB_ADDR_WIDTH'(FB_RESOLUTION_X) + FB_ADDR_WIDTH'(x);
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - show-ahead synchronous FIFO with occupancy level
module sync_fifo_fwft #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      head_data,
   output logic                  full,
   output logic                  empty,
   output logic                  pop_ok,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [WIDTH-1:0]      mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic                  push_ok;

   assign empty     = (level_q == '0);
   assign full      = (level_q == (DEPTH_LOG2+1)'(DEPTH));
   assign level     = level_q;
   assign head_data = mem_q[rd_ptr_q];

   // A full FIFO can still take a push when the head leaves in the same cycle; clear overrides both.
   assign pop_ok  = !clear && pop && !empty;
   assign push_ok = !clear && push && (!full || pop_ok);

   // Pointer and occupancy bookkeeping.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
         case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (DEPTH_LOG2+1)'(1);
            2'b01:   level_d = level_q - (DEPTH_LOG2+1)'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // Storage write port.
   always_comb begin
      mem_d = mem_q;
      if (push_ok) mem_d[wr_ptr_q] = push_data;
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents are only observed through the level-qualified head.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pipeline_image_upload_writer.sv
// rtl/pipeline_image_upload_writer.sv - pixel stream to framebuffer write-request bridge
module pipeline_image_upload_writer
   import pipeline_image_upload_writer_pkg::*;
#(
   parameter int PRECISION       = FB_PRECISION,
   parameter int PIXEL_SIZE      = FB_PIXEL_SIZE,
   parameter int RESOLUTION_X    = FB_RESOLUTION_X,
   parameter int RESOLUTION_Y    = FB_RESOLUTION_Y,
   parameter int ADDR_WIDTH      = FB_ADDR_WIDTH,
   parameter int FIFO_DEPTH_LOG2 = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic [PRECISION-1:0]       pixel_x,
   input  logic [PRECISION-1:0]       pixel_y,
   input  logic [PIXEL_SIZE-1:0]      pixel_data,
   input  logic                       pixel_ready,
   output logic                       mem_wr_req,
   output logic [ADDR_WIDTH-1:0]      mem_wr_addr,
   output logic [PIXEL_SIZE-1:0]      mem_wr_data,
   input  logic                       mem_wr_ack,
   output logic                       frame_done,
   output logic                       overflow,
   output logic                       range_error,
   output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

   localparam int EW = ADDR_WIDTH + PIXEL_SIZE + 1;
   localparam logic [PRECISION-1:0] MAX_X = PRECISION'(RESOLUTION_X - 1);
   localparam logic [PRECISION-1:0] MAX_Y = PRECISION'(RESOLUTION_Y - 1);

   logic                  valid_q, valid_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [PIXEL_SIZE-1:0] data_q, data_d;
   logic                  last_q, last_d;
   logic                  overflow_q, overflow_d;
   logic                  range_error_q, range_error_d;
   logic                  frame_done_q, frame_done_d;

   logic                  in_range;
   logic [EW-1:0]         head;
   logic                  fifo_full, fifo_empty, pop_ok;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [PIXEL_SIZE-1:0] head_data;
   logic                  head_last;

   assign in_range = (pixel_x <= MAX_X) && (pixel_y <= MAX_Y);
   assign {head_addr, head_data, head_last} = head;

   // Address stage, sticky error flags and end-of-frame detection.
   always_comb begin
      valid_d       = 1'b0;
      addr_d        = addr_q;
      data_d        = data_q;
      last_d        = last_q;
      overflow_d    = overflow_q;
      range_error_d = range_error_q;
      frame_done_d  = 1'b0;
      if (flush) begin
         overflow_d    = 1'b0;
         range_error_d = 1'b0;
      end else begin
         if (pixel_ready) begin
            if (in_range) begin
               valid_d = 1'b1;
               addr_d  = ADDR_WIDTH'(pixel_y) * ADDR_WIDTH'(RESOLUTION_X) + ADDR_WIDTH'(pixel_x);
               data_d  = pixel_data;
               last_d  = (pixel_x == MAX_X) && (pixel_y == MAX_Y);
            end else begin
               range_error_d = 1'b1;
            end
         end
         if (valid_q && fifo_full && !pop_ok) overflow_d = 1'b1;
         frame_done_d = pop_ok && head_last;
      end
   end

   // Stage and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q       <= 1'b0;
         addr_q        <= '0;
         data_q        <= '0;
         last_q        <= 1'b0;
         overflow_q    <= 1'b0;
         range_error_q <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         valid_q       <= valid_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         last_q        <= last_d;
         overflow_q    <= overflow_d;
         range_error_q <= range_error_d;
         frame_done_q  <= frame_done_d;
      end
   end

   sync_fifo_fwft #(
      .WIDTH      (EW),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (flush),
      .push      (valid_q),
      .push_data ({addr_q, data_q, last_q}),
      .pop       (mem_wr_ack),
      .head_data (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .pop_ok    (pop_ok),
      .level     (fifo_level)
   );

   // Head fields are gated so the bus reads zero whenever nothing is pending.
   assign mem_wr_req  = !fifo_empty;
   assign mem_wr_addr = mem_wr_req ? head_addr : '0;
   assign mem_wr_data = mem_wr_req ? head_data : '0;
   assign frame_done  = frame_done_q;
   assign overflow    = overflow_q;
   assign range_error = range_error_q;

endmodule

// File: tb/tb_pipeline_image_upload_writer.sv
// tb/tb_pipeline_image_upload_writer.sv - directed self-checking bench for the image upload writer
module tb_pipeline_image_upload_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [10:0] pixel_x;
   logic [10:0] pixel_y;
   logic [15:0] pixel_data;
   logic        pixel_ready;
   logic        mem_wr_req;
   logic [18:0] mem_wr_addr;
   logic [15:0] mem_wr_data;
   logic        mem_wr_ack;
   logic        frame_done;
   logic        overflow;
   logic        range_error;
   logic [3:0]  fifo_level;

   int n_cmp  = 0;
   int n_fail = 0;

   pipeline_image_upload_writer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .pixel_data  (pixel_data),
      .pixel_ready (pixel_ready),
      .mem_wr_req  (mem_wr_req),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .mem_wr_ack  (mem_wr_ack),
      .frame_done  (frame_done),
      .overflow    (overflow),
      .range_error (range_error),
      .fifo_level  (fifo_level)
   );

   always #5 clk = ~clk;

   // One-cycle strobe; returns on the falling edge after the capturing rising edge.
   task automatic strobe(input int x, input int y, input logic [15:0] d);
      pixel_x     = 11'(x);
      pixel_y     = 11'(y);
      pixel_data  = d;
      pixel_ready = 1'b1;
      @(negedge clk);
      pixel_ready = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; pixel_ready = 1'b0; mem_wr_ack = 1'b0;
      pixel_x = '0; pixel_y = '0; pixel_data = '0;
      idle(2);
      n_cmp++; if (mem_wr_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", mem_wr_req); end
      n_cmp++; if (mem_wr_addr !== 19'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", mem_wr_addr); end
      n_cmp++; if (mem_wr_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", mem_wr_data); end
      n_cmp++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
      n_cmp++; if ({frame_done, overflow, range_error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {frame_done, overflow, range_error}); end
      rst_n = 1'b1;
      idle(1);
   endtask

   task automatic test_single();
      mem_wr_ack = 1'b1;
      strobe(5, 2, 16'hF800);
      n_cmp++; if (mem_wr_req !== 1'b0) begin n_fail++; $display("FAIL single_req_early got %b exp 0", mem_wr_req); end
      idle(1);
      n_cmp++; if (mem_wr_req !== 1'b1) begin n_fail++; $display("FAIL single_req got %b exp 1", mem_wr_req); end
      n_cmp++; if (mem_wr_addr !== 19'd1605) begin n_fail++; $display("FAIL single_addr got %0d exp 1605", mem_wr_addr); end
      n_cmp++; if (mem_wr_data !== 16'hF800) begin n_fail++; $display("FAIL single_data got %h exp F800", mem_wr_data); end
      idle(1);
      n_cmp++; if (mem_wr_req !== 1'b0) begin n_fail++; $display("FAIL single_req_drop got %b exp 0", mem_wr_req); end
      n_cmp++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL single_level got %0d exp 0", fifo_level); end
      n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL single_frame_done got %b exp 0", frame_done); end
      mem_wr_ack = 1'b0;
   endtask

   task automatic test_overflow();
      mem_wr_ack = 1'b0;
      for (int i = 0; i < 9; i++) strobe(i, 0, 16'(i));
      idle(1);
      n_cmp++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level got %0d exp 8", fifo_level); end
      n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
      mem_wr_ack = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (mem_wr_addr !== 19'(i) || mem_wr_data !== 16'(i) || mem_wr_req !== 1'b1) begin
            n_fail++; $display("FAIL drain_%0d got req=%b addr=%0d data=%h exp req=1 addr=%0d data=%h", i, mem_wr_req, mem_wr_addr, mem_wr_data, i, 16'(i));
         end
         idle(1);
      end
      mem_wr_ack = 1'b0;
      n_cmp++; if (mem_wr_req !== 1'b0 || fifo_level !== 4'd0) begin n_fail++; $display("FAIL drain_empty got req=%b level=%0d exp 0/0", mem_wr_req, fifo_level); end
      n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
      do_flush();
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_flush got %b exp 0", overflow); end
   endtask

   task automatic test_full_push_pop();
      mem_wr_ack = 1'b0;
      for (int i = 0; i < 9; i++) strobe(10 + i, 1, 16'h0100 + 16'(i));
      mem_wr_ack = 1'b1;
      idle(1);
      mem_wr_ack = 1'b0;
      n_cmp++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL fpp_level got %0d exp 8", fifo_level); end
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow got %b exp 0", overflow); end
      n_cmp++; if (mem_wr_addr !== 19'd811 || mem_wr_data !== 16'h0101) begin n_fail++; $display("FAIL fpp_head got addr=%0d data=%h exp 811/0101", mem_wr_addr, mem_wr_data); end
      do_flush();
      n_cmp++; if (fifo_level !== 4'd0 || mem_wr_req !== 1'b0) begin n_fail++; $display("FAIL fpp_flush got level=%0d req=%b exp 0/0", fifo_level, mem_wr_req); end
   endtask

   task automatic test_range();
      strobe(800, 0, 16'h1111);
      strobe(0, 600, 16'h2222);
      idle(2);
      n_cmp++; if (mem_wr_req !== 1'b0 || fifo_level !== 4'd0) begin n_fail++; $display("FAIL range_noreq got req=%b level=%0d exp 0/0", mem_wr_req, fifo_level); end
      n_cmp++; if (range_error !== 1'b1) begin n_fail++; $display("FAIL range_flag got %b exp 1", range_error); end
      do_flush();
      n_cmp++; if (range_error !== 1'b0) begin n_fail++; $display("FAIL range_flush got %b exp 0", range_error); end
   endtask

   task automatic test_frame_done();
      int pulses;
      mem_wr_ack = 1'b0;
      strobe(799, 599, 16'h07E0);
      idle(1);
      n_cmp++; if (mem_wr_req !== 1'b1 || mem_wr_addr !== 19'd479999) begin n_fail++; $display("FAIL frame_head got req=%b addr=%0d exp 1/479999", mem_wr_req, mem_wr_addr); end
      n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_early got %b exp 0", frame_done); end
      mem_wr_ack = 1'b1;
      idle(1);
      mem_wr_ack = 1'b0;
      n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL frame_pulse got %b exp 1", frame_done); end
      pulses = 1;
      for (int i = 0; i < 4; i++) begin
         idle(1);
         if (frame_done === 1'b1) pulses++;
      end
      n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL frame_once got %0d pulses exp 1", pulses); end
   endtask

   task automatic test_reset_mid();
      mem_wr_ack = 1'b0;
      strobe(900, 0, 16'hAAAA);
      for (int i = 0; i < 4; i++) strobe(i, 3, 16'hC000 + 16'(i));
      idle(2);
      n_cmp++; if (fifo_level !== 4'd4 || range_error !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got level=%0d rerr=%b exp 4/1", fifo_level, range_error); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (mem_wr_req !== 1'b0 || fifo_level !== 4'd0) begin n_fail++; $display("FAIL rmid_req got req=%b level=%0d exp 0/0", mem_wr_req, fifo_level); end
      n_cmp++; if (mem_wr_addr !== 19'd0 || mem_wr_data !== 16'h0) begin n_fail++; $display("FAIL rmid_bus got addr=%0d data=%h exp 0/0", mem_wr_addr, mem_wr_data); end
      n_cmp++; if (range_error !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_flags got rerr=%b ovf=%b exp 0/0", range_error, overflow); end
      @(negedge clk);
      rst_n = 1'b1;
      idle(5);
      n_cmp++; if (mem_wr_req !== 1'b0 || fifo_level !== 4'd0) begin n_fail++; $display("FAIL rmid_after got req=%b level=%0d exp 0/0", mem_wr_req, fifo_level); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_full_push_pop();
      test_range();
      test_frame_done();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
